// File: rtl/mem_ctrl_mc.sv
// mem_ctrl_mc -- multi-client banked SRAM burst controller.
//
// Arbitrates burst requests from NUM_CLIENTS clients. The high-priority
// class (client_priority=1) is preferred. One request is accepted at a time.
// The accepted burst is split into row-aligned beats across NUM_BANKS banks.
// A beat never wraps past the top bank.
//
// Build option: define MEM_CTRL_RR_EN for round-robin arbitration within the
// candidate set. When it is undefined, the lowest client index wins.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/write   per-client request and direction (1 = write)
//   req_addr/req_len  per-client start word address / length, packed by client
//   client_priority   per-client priority class
//   req_ready         one-hot grant pulse (request consumed this cycle)
//   bank_ready        fabric accepts the current beat
//   bank_cs/bank_addr per-bank select and row address of the current beat
//   bank_we           write strobe for the current beat
//   beat_client       owner of the current beat
//   beat_base         word address of the first word in the beat
//   beat_num_valid    words in the beat (1..NUM_BANKS)
//   beat_last         final beat of the burst
//   busy              a burst is being issued
module mem_ctrl_mc #(
  parameter int NUM_CLIENTS = 5,
  parameter int NUM_BANKS   = 16,
  parameter int ADDR_W      = 32,
  parameter int SRAM_AW     = 19,
  parameter int MAX_LEN     = 64,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CLIENTS-1:0]                 req_valid,
  input  logic [NUM_CLIENTS-1:0]                 req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]          req_addr,
  input  logic [NUM_CLIENTS*LEN_W-1:0]           req_len,
  input  logic [NUM_CLIENTS-1:0]                 client_priority,
  output logic [NUM_CLIENTS-1:0]                 req_ready,
  input  logic                                   bank_ready,
  output logic [NUM_BANKS-1:0]                   bank_cs,
  output logic                                   bank_we,
  output logic [NUM_BANKS*SRAM_AW-1:0]           bank_addr,
  output logic [$clog2(NUM_CLIENTS)-1:0]         beat_client,
  output logic [SRAM_AW+$clog2(NUM_BANKS)-1:0]   beat_base,
  output logic [$clog2(NUM_BANKS):0]             beat_num_valid,
  output logic                                   beat_last,
  output logic                                   busy
);

  localparam int BK_W = $clog2(NUM_BANKS);
  localparam int CL_W = $clog2(NUM_CLIENTS);
  localparam int AW   = SRAM_AW + BK_W;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                     state;
  logic [AW-1:0]              cur_addr;
  logic [LEN_W-1:0]           rem;

  logic [NUM_CLIENTS-1:0]     pri_set, cand, grant_oh;
  logic                       any_valid, found;
  logic [CL_W-1:0]            win_idx;
  logic [LEN_W-1:0]           len_raw, win_len;

  logic [AW-1:0]              calc_addr;
  logic [LEN_W-1:0]           calc_rem;
  logic [NUM_BANKS-1:0]       calc_cs;
  logic [NUM_BANKS*SRAM_AW-1:0] calc_baddr;
  logic [SRAM_AW-1:0]         calc_row;
  logic [BK_W:0]              calc_n;
  logic                       calc_last;
  logic                       load_beat;
  int unsigned                b_u, r_u, room_u, n_u;

`ifdef MEM_CTRL_RR_EN
  logic [CL_W-1:0]            rr_ptr;
`endif

  // Arbitration: prefer the high-priority class whenever it has a requester.
  always_comb begin
    pri_set   = req_valid & client_priority;
    cand      = (|pri_set) ? pri_set : req_valid;
    any_valid = |req_valid;
    found     = 1'b0;
    win_idx   = '0;
`ifdef MEM_CTRL_RR_EN
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr) + k) % NUM_CLIENTS;
      if (!found && cand[idx]) begin
        found   = 1'b1;
        win_idx = CL_W'(idx);
      end
    end
`else
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (!found && cand[k]) begin
        found   = 1'b1;
        win_idx = CL_W'(k);
      end
    end
`endif
    grant_oh = any_valid ? (NUM_CLIENTS'(1) << win_idx) : '0;

    len_raw = req_len[32'(win_idx)*LEN_W +: LEN_W];
    if (len_raw == '0)
      win_len = LEN_W'(1);
    else if (32'(len_raw) > 32'(MAX_LEN))
      win_len = LEN_W'(MAX_LEN);
    else
      win_len = len_raw;
  end

  // The grant is combinational in IDLE. It is gated by rst_n so that req_ready
  // reads 0 while reset is held, like every other output.
  always_comb begin
    req_ready = (state == S_IDLE && rst_n) ? grant_oh : '0;
    busy      = (state == S_ISSUE);
    load_beat = (state == S_IDLE  && any_valid) ||
                (state == S_ISSUE && bank_ready && !beat_last);
  end

  // Address/remaining for the next beat to be registered. In IDLE these come
  // from the winner; otherwise they advance past the beat being shown.
  always_comb begin
    if (state == S_IDLE) begin
      calc_addr = req_addr[32'(win_idx)*ADDR_W +: AW];
      calc_rem  = win_len;
    end else begin
      calc_addr = cur_addr + AW'(beat_num_valid);
      calc_rem  = rem - LEN_W'(beat_num_valid);
    end
  end

  // Beat shape: start at the bank selected by the low bits and stop at the top bank.
  always_comb begin
    b_u        = 32'(calc_addr[BK_W-1:0]);
    r_u        = 32'(calc_rem);
    room_u     = 32'(NUM_BANKS) - b_u;
    n_u        = (r_u < room_u) ? r_u : room_u;
    calc_row   = calc_addr[AW-1:BK_W];
    calc_n     = (BK_W+1)'(n_u);
    calc_last  = (n_u == r_u);
    calc_cs    = '0;
    calc_baddr = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (i >= b_u && i < b_u + n_u) begin
        calc_cs[i]                      = 1'b1;
        calc_baddr[i*SRAM_AW +: SRAM_AW] = calc_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cur_addr       <= '0;
      rem            <= '0;
      bank_cs        <= '0;
      bank_we        <= 1'b0;
      bank_addr      <= '0;
      beat_client    <= '0;
      beat_base      <= '0;
      beat_num_valid <= '0;
      beat_last      <= 1'b0;
    end else begin
      if (state == S_IDLE && any_valid) begin
        state       <= S_ISSUE;
        bank_we     <= req_write[win_idx];
        beat_client <= win_idx;
      end else if (state == S_ISSUE && bank_ready && beat_last) begin
        state          <= S_IDLE;
        cur_addr       <= '0;
        rem            <= '0;
        bank_cs        <= '0;
        bank_we        <= 1'b0;
        bank_addr      <= '0;
        beat_client    <= '0;
        beat_base      <= '0;
        beat_num_valid <= '0;
        beat_last      <= 1'b0;
      end
      if (load_beat) begin
        cur_addr       <= calc_addr;
        rem            <= calc_rem;
        bank_cs        <= calc_cs;
        bank_addr      <= calc_baddr;
        beat_base      <= calc_addr;
        beat_num_valid <= calc_n;
        beat_last      <= calc_last;
      end
    end
  end

`ifdef MEM_CTRL_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (state == S_IDLE && any_valid)
      rr_ptr <= (32'(win_idx) == NUM_CLIENTS - 1) ? '0 : win_idx + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_ctrl_mc.sv
module tb_mem_ctrl_mc;
  localparam int NC = 5, NB = 16, AW = 32, SAW = 19, ML = 64, LW = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     req_valid, req_write, client_priority, req_ready;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*LW-1:0]  req_len;
  logic              bank_ready;
  logic [NB-1:0]     bank_cs;
  logic              bank_we;
  logic [NB*SAW-1:0] bank_addr;
  logic [2:0]        beat_client;
  logic [22:0]       beat_base;
  logic [4:0]        beat_num_valid;
  logic              beat_last, busy;

  int checks   = 0;
  int failures = 0;
  int unsigned exp_g [4];

  mem_ctrl_mc #(
    .NUM_CLIENTS(NC), .NUM_BANKS(NB), .ADDR_W(AW), .SRAM_AW(SAW), .MAX_LEN(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .client_priority(client_priority),
    .req_ready(req_ready), .bank_ready(bank_ready), .bank_cs(bank_cs),
    .bank_we(bank_we), .bank_addr(bank_addr), .beat_client(beat_client),
    .beat_base(beat_base), .beat_num_valid(beat_num_valid),
    .beat_last(beat_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] a, input logic [6:0] l);
    req_write[c]         = wr;
    req_addr[c*AW +: AW] = a;
    req_len[c*LW +: LW]  = l;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] cs, input logic [18:0] row,
                          input logic [4:0] n, input logic [22:0] base, input logic last,
                          input logic we, input logic [2:0] cl);
    logic [NB*SAW-1:0] ba;
    ba = '0;
    for (int i = 0; i < NB; i++)
      if (cs[i]) ba[i*SAW +: SAW] = row;
    chk({tag, ".cs"},     512'(bank_cs),        512'(cs));
    chk({tag, ".addr"},   512'(bank_addr),      512'(ba));
    chk({tag, ".n"},      512'(beat_num_valid), 512'(n));
    chk({tag, ".base"},   512'(beat_base),      512'(base));
    chk({tag, ".last"},   512'(beat_last),      512'(last));
    chk({tag, ".we"},     512'(bank_we),        512'(we));
    chk({tag, ".client"}, 512'(beat_client),    512'(cl));
    chk({tag, ".busy"},   512'(busy),           512'(1'b1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 512'(busy),           512'(1'b0));
    chk({tag, ".cs"},   512'(bank_cs),        512'(16'h0));
    chk({tag, ".addr"}, 512'(bank_addr),      512'(0));
    chk({tag, ".n"},    512'(beat_num_valid), 512'(5'd0));
    chk({tag, ".last"}, 512'(beat_last),      512'(1'b0));
    chk({tag, ".we"},   512'(bank_we),        512'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '1; req_write = '0; req_addr = '0; req_len = '0;
    client_priority = '0; bank_ready = 1'b1;
`ifdef MEM_CTRL_RR_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    // Reset state
    tick(); tick();
    chk_idle("rst");
    chk("rst.req_ready", 512'(req_ready), 512'(5'b0));
    chk("rst.client", 512'(beat_client), 512'(3'd0));
    chk("rst.base", 512'(beat_base), 512'(23'd0));
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single read: client 2, addr 0x23, len 20
    set_req(2, 1'b0, 32'h23, 7'd20);
    req_valid = 5'b00100; #1;
    chk("t1.grant", 512'(req_ready), 512'(5'b00100));
    tick(); req_valid = '0;
    chk_beat("t1.b1", 16'hFFF8, 19'd2, 5'd13, 23'h23, 1'b0, 1'b0, 3'd2);
    tick();
    chk_beat("t1.b2", 16'h007F, 19'd3, 5'd7, 23'h30, 1'b1, 1'b0, 3'd2);
    tick();
    chk_idle("t1.end");

    // Priority: clients 0 and 3, client 3 high priority
    set_req(0, 1'b0, 32'h5, 7'd3);
    set_req(3, 1'b1, 32'h10, 7'd4);
    client_priority = 5'b01000;
    req_valid = 5'b01001; #1;
    chk("t2.grant_hi", 512'(req_ready), 512'(5'b01000));
    tick(); req_valid = 5'b00001; #1;
    chk_beat("t2.c3", 16'h000F, 19'd1, 5'd4, 23'h10, 1'b1, 1'b1, 3'd3);
    chk("t2.no_grant_busy", 512'(req_ready), 512'(5'b0));
    tick();
    chk_idle("t2.gap");
    chk("t2.grant_lo", 512'(req_ready), 512'(5'b00001));
    tick(); req_valid = '0;
    chk_beat("t2.c0", 16'h00E0, 19'd0, 5'd3, 23'h5, 1'b1, 1'b0, 3'd0);
    tick();
    chk_idle("t2.end");
    client_priority = '0;

    // Write len 32 at addr 0, stall 3 cycles on beat 2
    set_req(1, 1'b1, 32'h0, 7'd32);
    req_valid = 5'b00010; #1;
    chk("t3.grant", 512'(req_ready), 512'(5'b00010));
    tick(); req_valid = '0;
    chk_beat("t3.b1", 16'hFFFF, 19'd0, 5'd16, 23'h0, 1'b0, 1'b1, 3'd1);
    tick(); bank_ready = 1'b0;
    chk_beat("t3.b2", 16'hFFFF, 19'd1, 5'd16, 23'h10, 1'b1, 1'b1, 3'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_beat("t3.hold", 16'hFFFF, 19'd1, 5'd16, 23'h10, 1'b1, 1'b1, 3'd1);
    end
    bank_ready = 1'b1;
    tick();
    chk_idle("t3.end");

    // Row wrap: row max, bank 15, len 2; address bits above the row are dropped
    set_req(4, 1'b0, 32'h807F_FFFF, 7'd2);
    req_valid = 5'b10000; #1;
    chk("t4.grant", 512'(req_ready), 512'(5'b10000));
    tick(); req_valid = '0;
    chk_beat("t4.b1", 16'h8000, 19'h7FFFF, 5'd1, 23'h7FFFFF, 1'b0, 1'b0, 3'd4);
    tick();
    chk_beat("t4.b2", 16'h0001, 19'd0, 5'd1, 23'h0, 1'b1, 1'b0, 3'd4);
    tick();
    chk_idle("t4.end");

    // Reset mid-burst, with other requests pending
    set_req(1, 1'b0, 32'h0, 7'd64);
    req_valid = 5'b00010; #1;
    chk("t5.grant", 512'(req_ready), 512'(5'b00010));
    tick(); req_valid = 5'b00101; #1;
    chk_beat("t5.b1", 16'hFFFF, 19'd0, 5'd16, 23'h0, 1'b0, 1'b0, 3'd1);
    chk("t5.no_grant_busy", 512'(req_ready), 512'(5'b0));
    rst_n = 1'b0; #1;
    chk_idle("t5.rst");
    chk("t5.rst.req_ready", 512'(req_ready), 512'(5'b0));
    chk("t5.rst.client", 512'(beat_client), 512'(3'd0));
    set_req(0, 1'b0, 32'h40, 7'd1);
    set_req(1, 1'b0, 32'h41, 7'd1);
    set_req(2, 1'b0, 32'h42, 7'd1);
    req_valid = 5'b00111;
    tick();
    rst_n = 1'b1; #1;
    chk("t5.regrant", 512'(req_ready), 512'(5'b00001));

    // Continuous requests from clients 0,1,2, len 1
    for (int g = 0; g < 4; g++) begin
      logic [4:0]  rv;
      logic [15:0] cs;
      rv = 5'b00001 << exp_g[g];
      cs = 16'h0001 << exp_g[g];
      chk("t6.grant", 512'(req_ready), 512'(rv));
      tick();
      chk_beat("t6.beat", cs, 19'd4, 5'd1, 23'(32'h40 + exp_g[g]), 1'b1, 1'b0, 3'(exp_g[g]));
      tick();
      chk_idle("t6.gap");
    end
    req_valid = '0;
    tick(); tick();
    chk_idle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_mc.md
# mem_ctrl_mc

Parametrised multi-client successor to the single-request memory controller. Arbitrates read/write burst requests from `NUM_CLIENTS` clients by priority class, splits each accepted burst into row-aligned beats across `NUM_BANKS` SRAM banks, and drives per-bank chip-select/address plus demux sideband (client id, base, last, valid count). Sits between the DDR-side clients and the banked SRAM/fabric demux.

## Interface
- `NUM_CLIENTS`, 5, requesting clients (≥2)
- `NUM_BANKS`, 16, SRAM banks, power of two (BK_W = log2)
- `ADDR_W`, 32, word address width of requests
- `SRAM_AW`, 19, per-bank address width
- `MAX_LEN`, 64, max burst length in words; LEN_W = $clog2(MAX_LEN+1)

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `req_valid` in NUM_CLIENTS — per-client request
- `req_write` in NUM_CLIENTS — 1 write, 0 read
- `req_addr` in NUM_CLIENTS×ADDR_W — start word address
- `req_len` in NUM_CLIENTS×LEN_W — words, 1..MAX_LEN
- `client_priority` in NUM_CLIENTS — 1 = high-priority class
- `req_ready` out NUM_CLIENTS — one-hot grant pulse, request consumed
- `bank_ready` in 1 — SRAM/fabric accepts current beat
- `bank_cs` out NUM_BANKS — per-bank select for current beat
- `bank_we` out 1 — write strobe (valid when any cs)
- `bank_addr` out NUM_BANKS×SRAM_AW — per-bank row address
- `beat_client` out $clog2(NUM_CLIENTS) — owner of current beat
- `beat_base` out SRAM_AW+BK_W — word address of first word in beat
- `beat_num_valid` out BK_W+1 — words in beat, 1..NUM_BANKS
- `beat_last` out 1 — final beat of burst
- `busy` out 1 — state ≠ IDLE

## Operation
- States: IDLE, ISSUE.
- IDLE: if any `req_valid`, candidate set = valid∧priority if non-empty, else all valid. Winner chosen per Configuration. `req_ready[winner]`=1 that cycle; latch write, addr, len (len 0 → 1; len > MAX_LEN impossible by width except MAX_LEN not 2^n−1: clamp to MAX_LEN). → ISSUE.
- ISSUE: beat from cur_addr: start bank b = cur_addr[BK_W-1:0], row = cur_addr[SRAM_AW+BK_W-1:BK_W] (higher bits dropped → row wraps mod 2^SRAM_AW). n = min(remaining, NUM_BANKS − b); beats never wrap across banks. `bank_cs` bits b..b+n−1 set, those `bank_addr` = row, other `bank_addr` = 0. `beat_last` = (n == remaining).
- Beat handshake: outputs held stable while `bank_ready`=0; on `bank_ready`=1 beat completes, cur_addr += n, remaining −= n. Last beat completes → IDLE with all beat outputs 0.
- Requests not granted keep `req_valid` asserted; no grant while in ISSUE.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, RR pointer 0, in-flight burst discarded; no partial beat after release.
- Grant at cycle T → first beat on outputs at T+1 (registered).
- Beat with `bank_ready`=1 at edge k → next beat visible k+1 (one beat/cycle at full throughput).
- Last beat accepted at k → IDLE at k+1, next grant earliest k+1, its first beat k+2 (one bubble between bursts).
- Burst of L words starting at bank b occupies ceil-style count: 1 + ceil(max(0, L−(NUM_BANKS−b))/NUM_BANKS) beats.
- Simultaneous requests from all clients: exactly one `req_ready` bit; never more.

## Configuration
- `MEM_CTRL_RR_EN` defined: round-robin within candidate set; pointer = last winner+1 (mod NUM_CLIENTS), search starts at pointer, updated only on grant. Pointer shared across both priority classes.
- Not defined: fixed priority, lowest index in candidate set wins; no pointer state.

## Test plan
- Client 2 alone, read, addr 0x23, len 20, NUM_BANKS 16 → grant T; beats: cs 0xFFF8 row 2 n 13, then cs 0x007F row 3 n 7 last; `bank_we`=0.
- Clients 0 and 3 valid, priority[3]=1 → client 3 granted first; client 0 after client 3's last beat + 1 cycle.
- `MEM_CTRL_RR_EN`, clients 0,1,2 continuously valid, equal priority, len 1 → grants 0,1,2,0; without macro → 0,0,0.
- `bank_ready` low 3 cycles on beat 2 of write len 32 at addr 0 → beat 2 outputs stable 4 cycles, 2 beats total, `bank_we`=1, `beat_last` only on beat 2.
- Addr with row = 2^SRAM_AW−1, bank 15, len 2 → beat1 row max cs bit15 n 1; beat2 row 0 cs bit0 last.
- `rst_n` low mid-burst → all outputs 0 immediately; after release, pending request re-granted from scratch, RR pointer 0.
